mmio_ctrl: RTL and testbench
============================

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter DBITS, default 32: address and data width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000: number of consecutive stable synchronized samples needed before a KEY/SW change is accepted.
REQ-003 clk  input  1: single processor clock; all state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 addr  input  DBITS: byte address of the processor load/store.
REQ-006 wr_en  input  1: store strobe, qualified by addr.
REQ-007 wr_data  input  DBITS: store data.
REQ-008 rd_en  input  1: load strobe, qualified by addr; used only for read side effects.
REQ-009 rd_data  output  DBITS: load data, combinational from addr and registered state.
REQ-010 KEY  input  4: raw, asynchronous pushbuttons.
REQ-011 SW  input  10: raw, asynchronous switches.
REQ-012 hex  output  16: four hex digits for the seven-segment decoders.
REQ-013 ledr  output  10: red LEDs.
REQ-014 ledg  output  8: green LEDs.

Function
REQ-015 The address map SHALL be: HEX 0xF0000000, LEDR 0xF0000004, LEDG 0xF0000008, KEY 0xF0000010, SW 0xF0000014, KEYCTRL 0xF0000110. Any other address is unmapped.
REQ-016 A store with wr_en=1 to HEX, LEDR or LEDG SHALL load wr_data[15:0], [9:0] or [7:0] into that register at the next edge.
REQ-017 Stores to KEY and SW SHALL be ignored.
REQ-018 Stores to unmapped addresses SHALL be ignored.
REQ-019 A load of an output register SHALL return that register's value, zero-extended.
REQ-020 A load of KEY or SW SHALL return the debounced value, zero-extended.
REQ-021 A load of KEYCTRL SHALL return {29'b0, overrun, 1'b0, ready}.
REQ-022 A load of an unmapped address SHALL return 0.
REQ-023 KEY and SW SHALL each pass through a two-flop synchronizer.
REQ-024 Debounce: each input group SHALL have one stability counter.
- The counter clears whenever the synchronized value differs from the candidate value.
- The debounced value updates once the counter reaches DEBOUNCE_CYCLES-1 with no intervening change.
- The counter saturates; it does not wrap.
REQ-025 State machine per group: STABLE -> (synchronized value != debounced value) -> SETTLING -> (counter terminal) -> STABLE with the debounced value updated.
- SETTLING -> (synchronized value returns to the debounced value) -> STABLE with no update.
REQ-026 A debounced KEY change SHALL set ready at the same edge.
- If ready is already 1 at that edge, overrun is also set.
REQ-027 rd_en=1 with addr=KEY SHALL clear ready at the next edge.
- If a debounced KEY change occurs on the same edge, set wins: ready stays 1 and overrun does not change.
REQ-028 A store to KEYCTRL SHALL clear ready where wr_data[0]=0 and clear overrun where wr_data[2]=0.
- A simultaneous set event wins over this clear.
REQ-029 From a real input change to the debounced update: DEBOUNCE_CYCLES+2 cycles (2 for synchronization).

Reset
REQ-030 While reset=0 at an edge, the following SHALL be cleared to 0: hex, ledr, ledg, ready, overrun, both counters, both synchronizer chains.
REQ-031 While reset=0 at an edge, the debounced KEY value SHALL load 4'hF (buttons released) and the debounced SW value SHALL load 0.
REQ-032 A reset during SETTLING SHALL abandon the pending change; no ready is set on reset exit.
REQ-033 Stores and loads presented while reset=0 SHALL have no effect.

Configuration
REQ-034 The macro MMIO_CTRL_DEBOUNCE_EN SHALL control debouncing.
- Defined: behaviour is REQ-024/REQ-025.
- Undefined: counters and the state machine are omitted, the debounced value equals the synchronized value (latency 2), and DEBOUNCE_CYCLES is ignored.

Structure
REQ-035 A shared package SHALL hold:
- all six address constants;
- the KEYCTRL bit indices (READY=0, OVERRUN=2);
- the debounce state enum {STABLE, SETTLING}.
REQ-036 Synchronizer plus debounce SHALL be one sub-module, mmio_debounce, parameterized by width and reset value, instantiated once for KEY (4) and once for SW (10).

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-037 Reset, then store 0x1234 to 0xF0000000 -> hex=0x1234 one edge later; load 0xF0000000 returns 0x00001234.
REQ-038 SW driven from 0 to 0x2A5 and held -> load 0xF0000014 returns 0x2A5 exactly 6 cycles later, not before.
REQ-039 SW glitches to 0x001 for 2 cycles, then returns to 0 -> debounced SW stays 0; ready unaffected.
REQ-040 KEY changes F->E, then later E->F, with no read in between -> KEYCTRL reads 0x5; store 0 to 0xF0000110 -> reads 0x0.
REQ-041 rd_en of KEY coincides with the edge on which a debounced change lands -> ready remains 1 and overrun remains 0.
REQ-042 Reset asserted mid-SETTLING, then released, with KEY held at E -> debounced KEY is F right after reset, E after 6 more cycles, and ready becomes 1 then.

Source files
------------

// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the MMIO controller: address map, KEYCTRL bit layout,
// debounce state encoding and the KEYCTRL read-word builder.
package mmio_ctrl_pkg;

    localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
    localparam logic [31:0] ADDR_KEYCTRL = 32'hF000_0110;

    localparam int KC_READY   = 0;
    localparam int KC_OVERRUN = 2;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_e;

    function automatic logic [31:0] keyctrl_word(input logic ready, input logic overrun);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[KC_READY]   = ready;
        w[KC_OVERRUN] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// Two-flop synchronizer plus optional debounce for one input group.
// Debounce logic is present only when MMIO_CTRL_DEBOUNCE_EN is defined.
module mmio_debounce
    import mmio_ctrl_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] RST_VAL         = {WIDTH{1'b0}},
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb,
    output logic             change
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [1:0]       prime_r;

    // Synchronizer chain; prime_r marks when the chain holds real samples again after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
            prime_r <= 2'b00;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            prime_r <= {prime_r[0], 1'b1};
        end
    end

`ifdef MMIO_CTRL_DEBOUNCE_EN
    // Update lands on the edge that takes the DEBOUNCE_CYCLES-th stable sample.
    localparam int               TERM   = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam int               CW     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]    TERM_C = CW'(TERM);
    localparam logic [CW-1:0]    CNT_MX = {CW{1'b1}};
    localparam bit               IMMED  = (DEBOUNCE_CYCLES <= 1);

    db_state_e        state_r, state_n;
    logic [WIDTH-1:0] deb_r, deb_n;
    logic [WIDTH-1:0] cand_r, cand_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic [WIDTH-1:0] eff_s;
    logic             change_s;

    // Next-state, candidate tracking and saturating stability counter
    always_comb begin
        eff_s    = prime_r[1] ? sync2_r : deb_r;
        state_n  = state_r;
        deb_n    = deb_r;
        cand_n   = cand_r;
        cnt_n    = cnt_r;
        change_s = 1'b0;
        case (state_r)
            STABLE: begin
                if (eff_s != deb_r) begin
                    if (IMMED) begin
                        deb_n    = eff_s;
                        change_s = 1'b1;
                    end else begin
                        state_n = SETTLING;
                        cand_n  = eff_s;
                        cnt_n   = {CW{1'b0}};
                    end
                end else begin
                    cnt_n = {CW{1'b0}};
                end
            end
            SETTLING: begin
                if (eff_s == deb_r) begin
                    state_n = STABLE;
                    cnt_n   = {CW{1'b0}};
                end else if (eff_s != cand_r) begin
                    cand_n = eff_s;
                    cnt_n  = {CW{1'b0}};
                end else if (cnt_r >= TERM_C) begin
                    state_n  = STABLE;
                    deb_n    = cand_r;
                    cnt_n    = {CW{1'b0}};
                    change_s = 1'b1;
                end else begin
                    cnt_n = (cnt_r == CNT_MX) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= STABLE;
            deb_r   <= RST_VAL;
            cand_r  <= RST_VAL;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_n;
            deb_r   <= deb_n;
            cand_r  <= cand_n;
            cnt_r   <= cnt_n;
        end
    end

    assign deb    = deb_r;
    assign change = change_s;
`else
    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] deb_n;

    // Debounced value is the synchronized value once the chain has refilled
    always_comb begin
        deb_s = prime_r[1] ? sync2_r : RST_VAL;
        deb_n = prime_r[0] ? sync1_r : RST_VAL;
    end

    assign deb    = deb_s;
    assign change = (deb_n != deb_s);
`endif

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O block: HEX/LEDR/LEDG output registers, debounced KEY/SW inputs
// and KEYCTRL ready/overrun flags. Debouncing is enabled by MMIO_CTRL_DEBOUNCE_EN.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      hex,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);

    logic [15:0] hex_r;
    logic [9:0]  ledr_r;
    logic [7:0]  ledg_r;
    logic        ready_r, ready_n;
    logic        overrun_r, overrun_n;
    logic [3:0]  key_deb;
    logic        key_chg;
    logic [9:0]  sw_deb;
    logic        sw_chg;
    logic        sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw, sel_kc;

    mmio_debounce #(
        .WIDTH           (4),
        .RST_VAL         (4'hF),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (KEY),
        .deb    (key_deb),
        .change (key_chg)
    );

    mmio_debounce #(
        .WIDTH           (10),
        .RST_VAL         (10'h000),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (SW),
        .deb    (sw_deb),
        .change (sw_chg)
    );

    // Address decode and load mux
    always_comb begin
        sel_hex  = (addr == DBITS'(ADDR_HEX));
        sel_ledr = (addr == DBITS'(ADDR_LEDR));
        sel_ledg = (addr == DBITS'(ADDR_LEDG));
        sel_key  = (addr == DBITS'(ADDR_KEY));
        sel_sw   = (addr == DBITS'(ADDR_SW));
        sel_kc   = (addr == DBITS'(ADDR_KEYCTRL));
        if (sel_hex) begin
            rd_data = DBITS'(hex_r);
        end else if (sel_ledr) begin
            rd_data = DBITS'(ledr_r);
        end else if (sel_ledg) begin
            rd_data = DBITS'(ledg_r);
        end else if (sel_key) begin
            rd_data = DBITS'(key_deb);
        end else if (sel_sw) begin
            rd_data = DBITS'(sw_deb);
        end else if (sel_kc) begin
            rd_data = DBITS'(keyctrl_word(ready_r, overrun_r));
        end else begin
            rd_data = {DBITS{1'b0}};
        end
    end

    // Ready/overrun update: a debounced KEY change beats any clear on the same edge
    always_comb begin
        ready_n   = ready_r;
        overrun_n = overrun_r;
        if (key_chg) begin
            ready_n   = 1'b1;
            overrun_n = overrun_r | ready_r;
        end else begin
            if ((rd_en && sel_key) || (wr_en && sel_kc && !wr_data[KC_READY])) begin
                ready_n = 1'b0;
            end else begin
                ready_n = ready_r;
            end
            if (wr_en && sel_kc && !wr_data[KC_OVERRUN]) begin
                overrun_n = 1'b0;
            end else begin
                overrun_n = overrun_r;
            end
        end
    end

    // Output registers and KEYCTRL flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_r     <= 16'h0000;
            ledr_r    <= 10'h000;
            ledg_r    <= 8'h00;
            ready_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_en && sel_hex) begin
                hex_r <= wr_data[15:0];
            end
            if (wr_en && sel_ledr) begin
                ledr_r <= wr_data[9:0];
            end
            if (wr_en && sel_ledg) begin
                ledg_r <= wr_data[7:0];
            end
            ready_r   <= ready_n;
            overrun_r <= overrun_n;
        end
    end

    assign hex  = hex_r;
    assign ledr = ledr_r;
    assign ledg = ledg_r;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl; load expectations go through a scoreboard queue.
module tb_mmio_ctrl;
    import mmio_ctrl_pkg::*;

    localparam int NDB = 4;
`ifdef MMIO_CTRL_DEBOUNCE_EN
    localparam int LAT    = NDB + 2;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 2;
    localparam bit DEB_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_ctrl #(
        .DBITS           (32),
        .DEBOUNCE_CYCLES (NDB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .KEY     (KEY),
        .SW      (SW),
        .hex     (hex),
        .ledr    (ledr),
        .ledg    (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] e);
        addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; KEY = 4'hF; SW = 10'h000;
        addr = 32'h0; wr_en = 1'b0; wr_data = 32'h0; rd_en = 1'b0;
        repeat (3) tick();
        check("rst_hex",  {16'h0, hex},  32'h0);
        check("rst_ledr", {22'h0, ledr}, 32'h0);
        check("rst_ledg", {24'h0, ledg}, 32'h0);
        load("rst_key", ADDR_KEY, 32'hF);
        load("rst_kc",  ADDR_KEYCTRL, 32'h0);
        store(ADDR_HEX, 32'h0000_DEAD);
        check("rst_store_ignored", {16'h0, hex}, 32'h0);

        reset = 1'b1;
        repeat (LAT + 2) tick();
        load("post_rst_key", ADDR_KEY, 32'hF);
        load("post_rst_sw",  ADDR_SW, 32'h0);
        load("post_rst_kc",  ADDR_KEYCTRL, 32'h0);

        store(ADDR_HEX, 32'h0000_1234);
        check("hex_store", {16'h0, hex}, 32'h1234);
        load("hex_load", ADDR_HEX, 32'h0000_1234);
        store(ADDR_LEDR, 32'hFFFF_FFFF);
        check("ledr_store", {22'h0, ledr}, 32'h3FF);
        load("ledr_load", ADDR_LEDR, 32'h0000_03FF);
        store(ADDR_LEDG, 32'h0000_01A5);
        check("ledg_store", {24'h0, ledg}, 32'hA5);
        load("ledg_load", ADDR_LEDG, 32'h0000_00A5);

        store(ADDR_KEY, 32'h0);
        store(ADDR_SW, 32'h3FF);
        store(32'hF000_000C, 32'hFFFF);
        store(32'hE000_0000, 32'hFFFF);
        check("unmapped_hex",  {16'h0, hex},  32'h1234);
        check("unmapped_ledr", {22'h0, ledr}, 32'h3FF);
        check("unmapped_ledg", {24'h0, ledg}, 32'hA5);
        load("key_ro", ADDR_KEY, 32'hF);
        load("sw_ro",  ADDR_SW, 32'h0);
        load("unmapped_rd0", 32'hF000_000C, 32'h0);
        load("unmapped_rd1", 32'hF000_0018, 32'h0);

        SW = 10'h2A5;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            load("sw_latency", ADDR_SW, (k == LAT) ? 32'h2A5 : 32'h0);
        end
        load("sw_no_ready", ADDR_KEYCTRL, 32'h0);
        SW = 10'h000;
        repeat (LAT) tick();
        load("sw_back0", ADDR_SW, 32'h0);

        SW = 10'h001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) SW = 10'h000;
            load("sw_glitch", ADDR_SW,
                 (!DEB_ON && (k == 2 || k == 3)) ? 32'h1 : 32'h0);
        end
        load("glitch_kc", ADDR_KEYCTRL, 32'h0);

        KEY = 4'hE;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            load("kc_ready_set", ADDR_KEYCTRL, (k == LAT) ? 32'h1 : 32'h0);
        end
        load("key_e", ADDR_KEY, 32'hE);
        KEY = 4'hF;
        repeat (LAT) tick();
        load("kc_overrun", ADDR_KEYCTRL, 32'h5);
        load("key_f", ADDR_KEY, 32'hF);
        store(ADDR_KEYCTRL, 32'h4);
        load("kc_clr_ready_only", ADDR_KEYCTRL, 32'h4);
        store(ADDR_KEYCTRL, 32'h0);
        load("kc_clr_all", ADDR_KEYCTRL, 32'h0);

        KEY = 4'hE;
        for (int k = 1; k < LAT; k++) tick();
        load("coinc_pre", ADDR_KEYCTRL, 32'h0);
        rd_en = 1'b1; addr = ADDR_KEY;
        tick();
        rd_en = 1'b0;
        load("coinc_set_wins", ADDR_KEYCTRL, 32'h1);
        rd_en = 1'b1; addr = ADDR_KEY;
        tick();
        rd_en = 1'b0;
        load("rd_clears_ready", ADDR_KEYCTRL, 32'h0);

        KEY = 4'hF;
        repeat (LAT) tick();
        store(ADDR_KEYCTRL, 32'h0);
        load("pre_rst_key", ADDR_KEY, 32'hF);
        load("pre_rst_kc", ADDR_KEYCTRL, 32'h0);
        KEY = 4'hE;
        repeat (LAT / 2 + 1) tick();
        reset = 1'b0;
        tick();
        tick();
        load("midrst_key", ADDR_KEY, 32'hF);
        load("midrst_kc", ADDR_KEYCTRL, 32'h0);
        check("midrst_hex", {16'h0, hex}, 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            load("rst_exit_key", ADDR_KEY, (k == LAT) ? 32'hE : 32'hF);
            load("rst_exit_kc", ADDR_KEYCTRL, (k == LAT) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
